mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BUSY_START_TO, default 4, max cycles from o_ce until i_busy must read 1.
REQ-002 Parameter BUSY_DONE_TO, default 255, max cycles i_busy may stay 1.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  3  request per requester: bit0 VIC, bit1 CPU, bit2 loader.
REQ-006 we  input  3  per-requester write enable (1 write, 0 read).
REQ-007 addr  input  48  per-requester 16-bit address, packed [16*i +: 16].
REQ-008 bank  input  21  per-requester 7-bit bank, packed [7*i +: 7].
REQ-009 wdata  input  24  per-requester write byte, packed [8*i +: 8].
REQ-010 gnt  output  3  one-cycle grant pulse to the winner.
REQ-011 ack  output  3  one-cycle completion pulse to the granted requester.
REQ-012 rdata  output  8  read byte, valid while ack is high.
REQ-013 err  output  1  pulses with ack when the transaction timed out.
REQ-014 o_fault  output  1  sticky timeout flag.
REQ-015 o_ce, o_write  output  1 each  memory controller strobe and direction.
REQ-016 o_bank  output  7; o_addr  output  16; o_wdata  output  8: latched transaction fields.
REQ-017 i_rdata  input  8; i_busy  input  1: memory controller read data and busy.

Function
REQ-018 FSM states: IDLE, WAIT_START, WAIT_DONE; all outputs registered.
REQ-019 IDLE: if any req bit is sampled high at an edge, the winner's we/addr/bank/wdata SHALL be latched, its gnt bit and o_ce driven high for exactly the next cycle, state -> WAIT_START.
REQ-020 Priority: VIC always wins; else CPU over loader, except that after 4 consecutive CPU grants while req[2] stayed high, the next non-VIC grant SHALL go to the loader; the counter SHALL clear on any loader grant or whenever req[2] is low.
REQ-021 o_write/o_addr/o_bank/o_wdata SHALL stay constant from the o_ce cycle until the ack cycle inclusive.
REQ-022 WAIT_START: i_busy==1 -> WAIT_DONE; any other value (0, X, Z) counts as not busy; BUSY_START_TO cycles without busy -> timeout.
REQ-023 WAIT_DONE: i_busy==0 -> next cycle ack[winner]=1, rdata=i_rdata (reads) or unchanged (writes), state IDLE; BUSY_DONE_TO cycles busy -> timeout.
REQ-024 Timeout: ack[winner]=1, err=1, rdata=8'hFF, o_fault set, state IDLE; no hang.
REQ-025 The ack cycle is an IDLE cycle: requests sampled at its end are arbitrated (back-to-back allowed).
REQ-026 Requester holds req and fields stable until gnt, drops req the cycle after gnt; a req bit still high after gnt is a new request.
REQ-027 Requests arriving outside IDLE SHALL wait; never lost, never reordered per requester.
REQ-028 At most one gnt, one ack and one transaction outstanding at any time.

Reset
REQ-029 reset low SHALL immediately force IDLE and zero gnt, ack, rdata, err, o_fault, o_ce, o_write, o_bank, o_addr, o_wdata, starvation counter and timeout counter.
REQ-030 Reset mid-transaction SHALL abort it silently (no ack); first grant possible at the first edge after reset deasserts.

Structure
REQ-031 Package gm64_pkg SHALL hold requester index enum (REQ_VIC=0, REQ_CPU=1, REQ_LDR=2), FSM state enum, FAIL_DATA=8'hFF, STARVE_LIMIT=4.
REQ-032 Winner selection plus starvation counter SHALL live in sub-module arb_prio; the FSM, latching and timeouts remain in mem_arbiter.

Verification
REQ-033 CPU read 0xC000 bank 0, busy high 3 cycles, i_rdata=8'hA9 -> gnt[1], o_ce one cycle, ack[1] with rdata=8'hA9, err=0.
REQ-034 VIC and CPU request same edge -> gnt[0] first; CPU granted the cycle after ack[0].
REQ-035 CPU and loader requesting continuously -> grant order CPU x4, loader, CPU x4, loader.
REQ-036 i_busy held 0 (then Z) after o_ce -> ack with err=1, rdata=8'hFF after BUSY_START_TO cycles; o_fault stays 1.
REQ-037 Reset asserted in WAIT_DONE -> all outputs 0, no ack; fresh CPU write 0xD020 data 8'h05 completes normally.

Source files
------------

// File: rtl/gm64_pkg.sv
// Shared types and constants for the memory arbiter.
package gm64_pkg;

    localparam int NUM_REQ = 3;
    localparam logic [7:0] FAIL_DATA = 8'hFF;
    localparam int STARVE_LIMIT = 4;

    // Requester index: the bit position of each requester in req/gnt/ack.
    typedef enum logic [1:0] {
        REQ_VIC = 2'd0,
        REQ_CPU = 2'd1,
        REQ_LDR = 2'd2
    } req_idx_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2
    } arb_state_e;

    // Fields latched from the winning requester for the whole transaction.
    typedef struct packed {
        logic        write;
        logic [6:0]  bank;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input req_idx_e idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-controller signals of the arbiter, bundled.
interface mem_arbiter_if;
    import gm64_pkg::*;

    // requester side
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    we;
    logic [16*NUM_REQ-1:0] addr;
    logic [7*NUM_REQ-1:0]  bank;
    logic [8*NUM_REQ-1:0]  wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    ack;
    logic [7:0]            rdata;
    logic                  err;
    logic                  o_fault;

    // memory-controller side
    logic                  o_ce;
    logic                  o_write;
    logic [6:0]            o_bank;
    logic [15:0]           o_addr;
    logic [7:0]            o_wdata;
    logic [7:0]            i_rdata;
    logic                  i_busy;

    modport slave (
        input  req, we, addr, bank, wdata, i_rdata, i_busy,
        output gnt, ack, rdata, err, o_fault, o_ce, o_write, o_bank, o_addr, o_wdata
    );

    modport master (
        output req, we, addr, bank, wdata, i_rdata, i_busy,
        input  gnt, ack, rdata, err, o_fault, o_ce, o_write, o_bank, o_addr, o_wdata
    );

endinterface

// File: rtl/mem_arbiter_arb_prio.sv
// Fixed-priority winner select (VIC > CPU > loader) with a loader
// anti-starvation counter that forces a loader turn after a run of CPU grants.
module arb_prio
    import gm64_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               arb_en,
    output req_idx_e           win_idx
);

    logic [2:0] starve_cnt;
    logic       ldr_turn;

    assign ldr_turn = req[REQ_LDR] && (starve_cnt >= 3'(STARVE_LIMIT));

    // Winner is combinational; the FSM only uses it when it actually grants.
    always_comb begin
        win_idx = REQ_VIC;
        if (req[REQ_VIC])
            win_idx = REQ_VIC;
        else if (req[REQ_CPU] && !ldr_turn)
            win_idx = REQ_CPU;
        else if (req[REQ_LDR])
            win_idx = REQ_LDR;
    end

    // Count CPU grants taken while the loader waits; a waiting loader is what
    // keeps the run alive, so a low req[LDR] clears it on every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (!req[REQ_LDR])
            starve_cnt <= '0;
        else if (arb_en && (|req)) begin
            if (win_idx == REQ_LDR)
                starve_cnt <= '0;
            else if (win_idx == REQ_CPU && starve_cnt < 3'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester memory arbiter: grants one transaction at a time, strobes
// the memory controller, tracks its busy handshake and times out on a stall.
module mem_arbiter
    import gm64_pkg::*;
#(
    parameter int BUSY_START_TO = 4,
    parameter int BUSY_DONE_TO  = 255
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int TO_MAX = (BUSY_DONE_TO > BUSY_START_TO) ? BUSY_DONE_TO : BUSY_START_TO;
    localparam int CNT_W  = $clog2(TO_MAX + 1);

    arb_state_e         state;
    req_idx_e           win;
    req_idx_e           cur;
    logic [CNT_W-1:0]   to_cnt;
    txn_t               sel;
    txn_t               lat;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] ack;
    logic [7:0]         rdata;
    logic               err;
    logic               fault;
    logic               ce;

    arb_prio u_prio (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req),
        .arb_en  (state == IDLE),
        .win_idx (win)
    );

    // Pick the current winner's fields out of the packed request buses.
    always_comb begin
        sel       = '0;
        sel.write = bus.we[win];
        sel.bank  = bus.bank[7*int'(win) +: 7];
        sel.addr  = bus.addr[16*int'(win) +: 16];
        sel.wdata = bus.wdata[8*int'(win) +: 8];
    end

    // Transaction FSM: grant, wait for busy to rise, wait for it to fall.
    // A stall in either wait completes the transaction with err and FAIL_DATA.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cur    <= REQ_VIC;
            to_cnt <= '0;
            lat    <= '0;
            gnt    <= '0;
            ack    <= '0;
            rdata  <= '0;
            err    <= 1'b0;
            fault  <= 1'b0;
            ce     <= 1'b0;
        end else begin
            gnt <= '0;
            ack <= '0;
            err <= 1'b0;
            ce  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        cur    <= win;
                        gnt    <= idx_onehot(win);
                        ce     <= 1'b1;
                        lat    <= sel;
                        to_cnt <= '0;
                        state  <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    // only a clean 1 counts as busy; 0, X and Z all keep waiting
                    if (bus.i_busy == 1'b1) begin
                        to_cnt <= '0;
                        state  <= WAIT_DONE;
                    end else if (to_cnt == CNT_W'(BUSY_START_TO - 1)) begin
                        ack   <= idx_onehot(cur);
                        err   <= 1'b1;
                        rdata <= FAIL_DATA;
                        fault <= 1'b1;
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.i_busy == 1'b0) begin
                        ack <= idx_onehot(cur);
                        if (!lat.write)
                            rdata <= bus.i_rdata;
                        state <= IDLE;
                    end else if (to_cnt == CNT_W'(BUSY_DONE_TO - 1)) begin
                        ack   <= idx_onehot(cur);
                        err   <= 1'b1;
                        rdata <= FAIL_DATA;
                        fault <= 1'b1;
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt;
    assign bus.ack     = ack;
    assign bus.rdata   = rdata;
    assign bus.err     = err;
    assign bus.o_fault = fault;
    assign bus.o_ce    = ce;
    assign bus.o_write = lat.write;
    assign bus.o_bank  = lat.bank;
    assign bus.o_addr  = lat.addr;
    assign bus.o_wdata = lat.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model of grant order and ack timing.
module tb_mem_arbiter;
    import gm64_pkg::*;

    localparam int T = 4;   // start timeout
    localparam int D = 12;  // done timeout

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.BUSY_START_TO(T), .BUSY_DONE_TO(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // model state
    bit          outst = 0;
    int          g_cyc, a_cyc, m_win;
    bit          m_err;
    logic [7:0]  m_rd, last_rd = 8'h00;
    bit          m_fault = 0;
    int          cpu_run = 0;
    logic        m_we;
    logic [15:0] m_addr;
    logic [6:0]  m_bank;
    logic [7:0]  m_wd;
    int          cur_s, cur_h;
    logic [7:0]  cur_rd = 8'h00;

    // stimulus knobs (-1 = random)
    int f_s = -1, f_h = -1, f_rd = -1;
    bit busy_z = 0, auto_drop = 1, rand_mode = 0;

    // observations of the DUT for the directed checks
    int         gq[$];
    int         last_gnt_cyc[3];
    int         last_ack_cyc[3];
    logic       last_err;
    logic [7:0] last_rdata_obs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict what the last edge should have produced, compare,
    // then drive requesters and the memory controller for the next edge.
    task automatic step();
        logic [2:0]  p_req, p_we;
        logic [47:0] p_addr;
        logic [20:0] p_bank;
        logic [23:0] p_wd;
        bit          gnow;
        bit          ack_now;
        int          k;
        p_req = bus.req; p_we = bus.we; p_addr = bus.addr; p_bank = bus.bank; p_wd = bus.wdata;
        @(negedge clk);
        cyc++;
        gnow = 0;
        if (!outst && p_req != 3'b000) begin
            if (p_req[0])
                m_win = 0;
            else if (p_req[1] && !(p_req[2] && cpu_run >= STARVE_LIMIT)) begin
                m_win = 1;
                cpu_run++;
            end else begin
                m_win = 2;
                cpu_run = 0;
            end
            gnow = 1; outst = 1; g_cyc = cyc;
            m_we = p_we[m_win];
            m_addr = p_addr[16*m_win +: 16];
            m_bank = p_bank[7*m_win +: 7];
            m_wd = p_wd[8*m_win +: 8];
            cur_s = (f_s >= 0) ? f_s : $urandom_range(0, T);
            cur_h = (f_h >= 0) ? f_h : $urandom_range(1, D + 1);
            cur_rd = (f_rd >= 0) ? 8'(f_rd) : 8'($urandom);
            if (cur_s >= T) begin
                a_cyc = g_cyc + T; m_err = 1; m_rd = 8'hFF;
            end else if (cur_h > D) begin
                a_cyc = g_cyc + cur_s + D + 1; m_err = 1; m_rd = 8'hFF;
            end else begin
                a_cyc = g_cyc + cur_s + cur_h + 1; m_err = 0;
                m_rd = m_we ? last_rd : cur_rd;
            end
        end
        if (!p_req[2]) cpu_run = 0;
        ack_now = outst && (cyc == a_cyc);
        if (ack_now && m_err) m_fault = 1;

        check("gnt", bus.gnt, gnow ? (3'b001 << m_win) : 3'b000);
        check("o_ce", bus.o_ce, gnow);
        check("ack", bus.ack, ack_now ? (3'b001 << m_win) : 3'b000);
        check("err", bus.err, ack_now && m_err);
        check("o_fault", bus.o_fault, m_fault);
        if (outst)
            check("fields", {bus.o_write, bus.o_bank, bus.o_addr, bus.o_wdata},
                  {m_we, m_bank, m_addr, m_wd});
        if (ack_now) begin
            check("rdata", bus.rdata, m_rd);
            last_rd = m_rd;
            outst = 0;
        end

        for (int i = 0; i < 3; i++) begin
            if (bus.gnt[i]) begin gq.push_back(i); last_gnt_cyc[i] = cyc; end
            if (bus.ack[i]) begin
                last_ack_cyc[i] = cyc; last_err = bus.err; last_rdata_obs = bus.rdata;
            end
        end

        if (gnow && auto_drop) bus.req[m_win] = 1'b0;
        if (rand_mode) begin
            for (int i = 0; i < 3; i++) begin
                if (!bus.req[i] && !(gnow && i == m_win) && $urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.we[i] = 1'($urandom);
                    bus.addr[16*i +: 16] = 16'($urandom);
                    bus.bank[7*i +: 7] = 7'($urandom);
                    bus.wdata[8*i +: 8] = 8'($urandom);
                end
            end
        end
        if (outst) begin
            k = cyc - g_cyc;
            if (busy_z && k >= 2) bus.i_busy = 1'bz;
            else bus.i_busy = (k >= cur_s && k < cur_s + cur_h);
        end else begin
            bus.i_busy = 1'b0;
        end
        bus.i_rdata = cur_rd;
    endtask

    task automatic wait_quiet(input int max);
        int n = 0;
        while ((outst || bus.req != 3'b000) && n < max) begin
            step();
            n++;
        end
        check("quiet_timeout", n < max, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        bus.req = 3'b000;
        bus.i_busy = 1'b0;
        #1;
        check("reset_outs", {bus.gnt, bus.ack, bus.rdata, bus.err, bus.o_fault, bus.o_ce,
                             bus.o_write, bus.o_bank, bus.o_addr, bus.o_wdata}, 64'd0);
        outst = 0; cpu_run = 0; last_rd = 8'h00; m_fault = 0;
        repeat (2) begin @(negedge clk); cyc++; end
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int rel;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.bank = '0; bus.wdata = '0;
        bus.i_rdata = '0; bus.i_busy = 1'b0;
        do_reset();

        // CPU read 0xC000 bank 0, busy 3 cycles, data A9
        f_s = 1; f_h = 3; f_rd = 8'hA9; gq.delete();
        bus.we[1] = 1'b0; bus.addr[31:16] = 16'hC000; bus.bank[13:7] = 7'd0; bus.req[1] = 1'b1;
        wait_quiet(40);
        check("t033_ngnt", gq.size(), 1);
        check("t033_who", gq[0], 1);
        check("t033_err", last_err, 1'b0);
        check("t033_rdata", last_rdata_obs, 8'hA9);
        check("t033_lat", last_ack_cyc[1] - last_gnt_cyc[1], 5);

        // VIC and CPU on the same edge: VIC first, CPU right after ack[0]
        f_s = 0; f_h = 1; f_rd = -1; gq.delete();
        bus.req[0] = 1'b1; bus.req[1] = 1'b1;
        wait_quiet(40);
        check("t034_first", gq[0], 0);
        check("t034_second", gq[1], 1);
        check("t034_b2b", last_gnt_cyc[1], last_ack_cyc[0] + 1);

        // CPU and loader held high: CPU x4, loader, CPU x4, loader
        auto_drop = 0; gq.delete();
        bus.req[1] = 1'b1; bus.req[2] = 1'b1;
        n = 0;
        while (gq.size() < 10 && n < 300) begin step(); n++; end
        bus.req = 3'b000;
        wait_quiet(40);
        auto_drop = 1;
        check("t035_count", gq.size(), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("t035_g%0d", i), gq[i], (i % 5 == 4) ? 2 : 1);

        // busy never rises (0 then Z): start timeout
        f_s = T; busy_z = 1; bus.req[1] = 1'b1;
        wait_quiet(40);
        busy_z = 0;
        check("t036_err", last_err, 1'b1);
        check("t036_rdata", last_rdata_obs, 8'hFF);
        check("t036_lat", last_ack_cyc[1] - last_gnt_cyc[1], T);
        check("t036_fault", bus.o_fault, 1'b1);
        // latest legal busy start, then fault must stay set
        f_s = T - 1; f_h = 1; bus.req[1] = 1'b1;
        wait_quiet(40);
        check("t036_late_ok", last_err, 1'b0);
        check("t036_sticky", bus.o_fault, 1'b1);

        // done-timeout boundary: D busy cycles legal, D+1 times out
        f_s = 0; f_h = D; bus.req[2] = 1'b1;
        wait_quiet(40);
        check("tdone_edge_err", last_err, 1'b0);
        check("tdone_edge_lat", last_ack_cyc[2] - last_gnt_cyc[2], D + 1);
        f_h = D + 1; bus.req[2] = 1'b1;
        wait_quiet(40);
        check("tdone_to_err", last_err, 1'b1);
        check("tdone_to_rdata", last_rdata_obs, 8'hFF);

        // reset in WAIT_DONE aborts silently; fresh CPU write completes
        f_s = 0; f_h = D; bus.req[1] = 1'b1;
        repeat (3) step();
        do_reset();
        f_s = 1; f_h = 2; gq.delete();
        bus.we[1] = 1'b1; bus.addr[31:16] = 16'hD020; bus.wdata[15:8] = 8'h05; bus.req[1] = 1'b1;
        rel = cyc;
        wait_quiet(40);
        check("t037_ngnt", gq.size(), 1);
        check("t037_first_edge", last_gnt_cyc[1], rel + 1);
        check("t037_err", last_err, 1'b0);
        check("t037_fault", bus.o_fault, 1'b0);

        // random traffic
        f_s = -1; f_h = -1; f_rd = -1; rand_mode = 1;
        repeat (800) step();
        rand_mode = 0;
        wait_quiet(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
